// File: rtl/xs3_serial_ctrl.sv
// xs3_serial_ctrl: serial BCD -> Excess-3 converter controller.
// One BCD digit per frame arrives as 4 bits LSB-first under valid/ready. Each
// accepted bit is added to the matching bit of constant 3 (0011) through a
// one-bit ripple adder, and the result bit is emitted LSB-first. out_last marks
// bit 3. The final carry is dropped, so the result is digit + 3 mod 16.
// All state changes on the falling edge of CLK. ClrN is an asynchronous,
// active-low reset.
// Optional feature macro: XS3_BCD_CHECK_EN. When it is defined, the err port
// flags digits 10..15 on the out_last beat.
module xs3_serial_ctrl #(
    parameter int DIGIT_CNT_W = 8
) (
    input  logic                   CLK,
    input  logic                   ClrN,
    input  logic                   in_valid,
    input  logic                   in_bit,
    output logic                   in_ready,
    input  logic                   abort,
    output logic                   out_valid,
    output logic                   out_bit,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic [DIGIT_CNT_W-1:0] digit_cnt
`ifdef XS3_BCD_CHECK_EN
    ,
    output logic                   err
`endif
);

    typedef enum logic [1:0] {
        BIT0 = 2'd0,
        BIT1 = 2'd1,
        BIT2 = 2'd2,
        BIT3 = 2'd3
    } bit_pos_t;

    // One ripple-adder step against constant 0011. Returns {carry_next, sum}.
    function automatic logic [1:0] xs3_step(input bit_pos_t pos, input logic b, input logic c);
        logic [1:0] res;
        case (pos)
            BIT0:    res = {b, ~b};
            BIT1:    res = {b | c, ~(b ^ c)};
            BIT2:    res = {b & c, b ^ c};
            BIT3:    res = {1'b0, b ^ c};
            default: res = {1'b0, 1'b0};
        endcase
        return res;
    endfunction

    bit_pos_t               state_r, state_s;
    logic                   carry_r, carry_s;
    logic                   out_valid_r, out_valid_s;
    logic                   out_bit_r, out_bit_s;
    logic                   out_last_r, out_last_s;
    logic [DIGIT_CNT_W-1:0] digit_cnt_r, digit_cnt_s;
    logic                   in_ready_s;
    logic                   in_xfer_s;
    logic                   out_xfer_s;
    logic [1:0]             step_s;
`ifdef XS3_BCD_CHECK_EN
    logic                   b1_seen_r, b1_seen_s;
    logic                   b2_or_r, b2_or_s;
    logic                   err_r, err_s;
`endif

    // Single-stage output register: a new bit can enter whenever the slot is empty or draining.
    assign in_ready_s = ClrN & (~out_valid_r | out_ready);

    // Next-state, adder and output-register logic. abort takes priority over both transfers.
    always_comb begin
        state_s     = state_r;
        carry_s     = carry_r;
        out_valid_s = out_valid_r;
        out_bit_s   = out_bit_r;
        out_last_s  = out_last_r;
        digit_cnt_s = digit_cnt_r;
`ifdef XS3_BCD_CHECK_EN
        b1_seen_s   = b1_seen_r;
        b2_or_s     = b2_or_r;
        err_s       = err_r;
`endif
        in_xfer_s   = in_valid & in_ready_s;
        out_xfer_s  = out_valid_r & out_ready;
        step_s      = xs3_step(state_r, in_bit, carry_r);

        if (abort) begin
            state_s     = BIT0;
            carry_s     = 1'b0;
            out_valid_s = 1'b0;
            out_bit_s   = 1'b0;
            out_last_s  = 1'b0;
`ifdef XS3_BCD_CHECK_EN
            b1_seen_s   = 1'b0;
            b2_or_s     = 1'b0;
            err_s       = 1'b0;
`endif
        end else if (in_xfer_s) begin
            carry_s     = step_s[1];
            out_bit_s   = step_s[0];
            out_valid_s = 1'b1;
            out_last_s  = (state_r == BIT3);
`ifdef XS3_BCD_CHECK_EN
            err_s       = (state_r == BIT3) & in_bit & b2_or_r;
`endif
            case (state_r)
                BIT0: begin
                    state_s = BIT1;
                end
                BIT1: begin
                    state_s = BIT2;
`ifdef XS3_BCD_CHECK_EN
                    b1_seen_s = in_bit;
`endif
                end
                BIT2: begin
                    state_s = BIT3;
`ifdef XS3_BCD_CHECK_EN
                    b2_or_s = b1_seen_r | in_bit;
`endif
                end
                BIT3: begin
                    state_s     = BIT0;
                    digit_cnt_s = digit_cnt_r + DIGIT_CNT_W'(1);
`ifdef XS3_BCD_CHECK_EN
                    b1_seen_s   = 1'b0;
                    b2_or_s     = 1'b0;
`endif
                end
                default: begin
                    state_s = BIT0;
                end
            endcase
        end else if (out_xfer_s) begin
            out_valid_s = 1'b0;
            out_last_s  = 1'b0;
`ifdef XS3_BCD_CHECK_EN
            err_s       = 1'b0;
`endif
        end else begin
            out_valid_s = out_valid_r;
        end
    end

    // Falling-edge state register with asynchronous active-low clear.
    always_ff @(negedge CLK or negedge ClrN) begin
        if (!ClrN) begin
            state_r     <= BIT0;
            carry_r     <= 1'b0;
            out_valid_r <= 1'b0;
            out_bit_r   <= 1'b0;
            out_last_r  <= 1'b0;
            digit_cnt_r <= {DIGIT_CNT_W{1'b0}};
`ifdef XS3_BCD_CHECK_EN
            b1_seen_r   <= 1'b0;
            b2_or_r     <= 1'b0;
            err_r       <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            carry_r     <= carry_s;
            out_valid_r <= out_valid_s;
            out_bit_r   <= out_bit_s;
            out_last_r  <= out_last_s;
            digit_cnt_r <= digit_cnt_s;
`ifdef XS3_BCD_CHECK_EN
            b1_seen_r   <= b1_seen_s;
            b2_or_r     <= b2_or_s;
            err_r       <= err_s;
`endif
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_bit   = out_bit_r;
    assign out_last  = out_last_r;
    assign digit_cnt = digit_cnt_r;
`ifdef XS3_BCD_CHECK_EN
    assign err       = err_r;
`endif

endmodule

// File: tb/tb_xs3_serial_ctrl.sv
// Bench for xs3_serial_ctrl. The model tracks the partial digit value and
// derives each output bit as bit i of (partial + 3). It is checked on every
// rising edge, away from the active falling edge. Directed digits also check
// hand-computed bit patterns.
module tb_xs3_serial_ctrl;
    localparam int CW = 8;

    logic          CLK = 1'b1;
    logic          ClrN;
    logic          in_valid;
    logic          in_bit;
    logic          in_ready;
    logic          abort;
    logic          out_valid;
    logic          out_bit;
    logic          out_last;
    logic          out_ready;
    logic [CW-1:0] digit_cnt;
`ifdef XS3_BCD_CHECK_EN
    logic          err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    xs3_serial_ctrl #(.DIGIT_CNT_W(CW)) dut (
        .CLK(CLK), .ClrN(ClrN), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready), .abort(abort), .out_valid(out_valid),
        .out_bit(out_bit), .out_last(out_last), .out_ready(out_ready),
        .digit_cnt(digit_cnt)
`ifdef XS3_BCD_CHECK_EN
        , .err(err)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: partial digit value, bit position, expected output slot.
    int   m_pos = 0;
    int   m_part = 0;
    int   m_cnt = 0;
    logic m_valid = 1'b0;
    logic m_bit = 1'b0;
    logic m_last = 1'b0;
    logic m_err = 1'b0;

    // Model update on the active edge.
    always @(negedge CLK or negedge ClrN) begin
        logic acc;
        int   np;
        if (!ClrN) begin
            m_pos <= 0; m_part <= 0; m_cnt <= 0;
            m_valid <= 1'b0; m_bit <= 1'b0; m_last <= 1'b0; m_err <= 1'b0;
        end else if (abort) begin
            m_pos <= 0; m_part <= 0;
            m_valid <= 1'b0; m_last <= 1'b0; m_err <= 1'b0;
        end else begin
            acc = in_valid && (!m_valid || out_ready);
            if (acc) begin
                np = m_part | (int'(in_bit) << m_pos);
                m_bit   <= 1'(((np + 3) >> m_pos) & 1);
                m_last  <= (m_pos == 3);
                m_err   <= (m_pos == 3) && (np > 9);
                m_valid <= 1'b1;
                if (m_pos == 3) begin
                    m_pos <= 0; m_part <= 0; m_cnt <= (m_cnt + 1) % (1 << CW);
                end else begin
                    m_pos <= m_pos + 1; m_part <= np;
                end
            end else if (m_valid && out_ready) begin
                m_valid <= 1'b0; m_last <= 1'b0; m_err <= 1'b0;
            end
        end
    end

    // Per-cycle comparison of the DUT against the model.
    always @(posedge CLK) begin
        chk("out_valid", int'(out_valid), int'(m_valid));
        chk("in_ready", int'(in_ready), int'(ClrN && (!m_valid || out_ready)));
        chk("digit_cnt", int'(digit_cnt), m_cnt);
        if (m_valid) begin
            chk("out_bit", int'(out_bit), int'(m_bit));
            chk("out_last", int'(out_last), int'(m_last));
        end
        if (!ClrN) begin
            chk("rst_out_bit", int'(out_bit), 0);
            chk("rst_out_last", int'(out_last), 0);
        end
`ifdef XS3_BCD_CHECK_EN
        chk("err", int'(err), int'(m_err));
`endif
    end

    // Log of every output transfer (sampled before the edge that takes it).
    logic log_bit  [0:4095];
    logic log_last [0:4095];
    logic log_err  [0:4095];
    int   log_n = 0;

    // Output collector.
    always @(posedge CLK) begin
        if (ClrN && out_valid && out_ready && log_n < 4096) begin
            log_bit[log_n]  <= out_bit;
            log_last[log_n] <= out_last;
`ifdef XS3_BCD_CHECK_EN
            log_err[log_n]  <= err;
`else
            log_err[log_n]  <= 1'b0;
`endif
            log_n <= log_n + 1;
        end
    end

    task automatic send_bit(input logic b, output int waits);
        logic ok;
        ok = 1'b0;
        waits = 0;
        in_valid = 1'b1;
        in_bit = b;
        for (int k = 0; k < 20; k++) begin
            @(posedge CLK);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            waits++;
            @(negedge CLK); #1;
            out_ready = 1'b1;
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(negedge CLK); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_digit(input int v, input logic bp, output int waits);
        int w;
        waits = 0;
        for (int i = 0; i < 4; i++) begin
            if (bp) out_ready = 1'($urandom_range(0, 1));
            send_bit(1'((v >> i) & 1), w);
            waits += w;
        end
    endtask

    task automatic settle();
        out_ready = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK); #1;
    endtask

    task automatic expect_bits(input string name, input int start, input int exp_val,
                               input int exp_last, input int exp_err);
        int v, l, e;
        v = 0; l = 0; e = 0;
        chk({name, "_count"}, int'(log_n - start >= 4), 1);
        if (log_n - start >= 4) begin
            for (int i = 0; i < 4; i++) begin
                v |= int'(log_bit[start + i]) << i;
                l |= int'(log_last[start + i]) << i;
                e |= int'(log_err[start + i]) << i;
            end
            chk({name, "_bits"}, v, exp_val);
            chk({name, "_last"}, l, exp_last);
            if (exp_err >= 0) chk({name, "_err"}, e, exp_err);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, w, tw;
        ClrN = 1'b0; in_valid = 1'b0; in_bit = 1'b0; abort = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge CLK);
        @(posedge CLK); #1;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_in_ready", int'(in_ready), 0);
        chk("reset_digit_cnt", int'(digit_cnt), 0);
        @(negedge CLK); #1;
        ClrN = 1'b1;
        @(posedge CLK); #1;
        chk("post_reset_in_ready", int'(in_ready), 1);
        @(negedge CLK); #1;

        // Digit 5 -> 8 (LSB-first 0,0,0,1).
        s = log_n;
        send_digit(5, 1'b0, w);
        settle();
        expect_bits("digit5", s, 4'b1000, 4'b1000, -1);
        chk("digit5_cnt", int'(digit_cnt), 1);

        // Digits 0 and 9 back-to-back with no stall.
        s = log_n; tw = 0;
        send_digit(0, 1'b0, w); tw += w;
        send_digit(9, 1'b0, w); tw += w;
        settle();
        chk("stream_stalls", tw, 0);
        expect_bits("digit0", s, 4'b0011, 4'b1000, -1);
        expect_bits("digit9", s + 4, 4'b1100, 4'b1000, -1);
        chk("stream_cnt", int'(digit_cnt), 3);

        // Digit 7 with 3 edges of backpressure after bit 1.
        s = log_n;
        send_bit(1'b1, w);
        send_bit(1'b1, w);
        out_ready = 1'b0;
        in_valid = 1'b1; in_bit = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK); #1;
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_bit", int'(out_bit), 1);
            chk("bp_out_valid", int'(out_valid), 1);
            @(negedge CLK); #1;
        end
        out_ready = 1'b1;
        send_bit(1'b1, w);
        send_bit(1'b0, w);
        settle();
        expect_bits("digit7", s, 4'b1010, 4'b1000, -1);
        chk("digit7_cnt", int'(digit_cnt), 4);

        // Reset pulse after bit 2, then digit 2 -> 5.
        send_bit(1'b1, w);
        send_bit(1'b0, w);
        send_bit(1'b1, w);
        #2 ClrN = 1'b0;
        @(posedge CLK); #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_cnt", int'(digit_cnt), 0);
        @(negedge CLK); #1;
        ClrN = 1'b1;
        s = log_n;
        send_digit(2, 1'b0, w);
        settle();
        expect_bits("digit2", s, 4'b0101, 4'b1000, -1);
        chk("digit2_cnt", int'(digit_cnt), 1);

        // abort after bit 1 (with an input presented), then digit 3 -> 6.
        send_bit(1'b1, w);
        send_bit(1'b0, w);
        abort = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        @(negedge CLK); #1;
        abort = 1'b0; in_valid = 1'b0;
        @(posedge CLK); #1;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_cnt", int'(digit_cnt), 1);
        @(negedge CLK); #1;
        s = log_n;
        send_digit(3, 1'b0, w);
        settle();
        expect_bits("digit3", s, 4'b0110, 4'b1000, -1);
        chk("digit3_cnt", int'(digit_cnt), 2);

        // Digit 12 -> 15 (err on last beat when checking), digit 8 -> 11.
        s = log_n;
        send_digit(12, 1'b0, w);
        settle();
`ifdef XS3_BCD_CHECK_EN
        expect_bits("digit12", s, 4'b1111, 4'b1000, 4'b1000);
`else
        expect_bits("digit12", s, 4'b1111, 4'b1000, -1);
`endif
        s = log_n;
        send_digit(8, 1'b0, w);
        settle();
        expect_bits("digit8", s, 4'b1011, 4'b1000, 0);

        // Random backpressure run up to counter wrap (4 + 252 = 256 -> 0).
        for (int d = 0; d < 252; d++) begin
            send_digit(d % 16, 1'b1, w);
        end
        settle();
        chk("wrap_cnt", int'(digit_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
